fu_mul_pipe: RTL and testbench
==============================

Name: fu_mul_pipe

Overview:
Parametrised, backpressure-aware integer multiply functional unit. It executes RV64 M-extension multiplies (MUL, MULH, MULHSU, MULHU, MULW) and sits between the issue queue and a shared writeback port. Unlike the first-generation unit, it has a configurable input register stage and configurable output depth. It also honours a writeback ready signal by stalling its pipeline instead of assuming the writeback port is always free.

Parameters:
PIPE_OUT, 2, number of product pipeline stages after the multiplier (>=1)
REG_IN, 1, 1 = register operands/op before the multiplier (retiming stage); 0 = multiplier fed combinationally from fuinput_i
PERF_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
fuinput_i  in  fu_input_t  pc, id, op.mul, prd, rs1val, rs2val
fuinput_i_valid  in  1  input valid
fuinput_i_ready  out  1  unit can accept this cycle
fuoutput_o  out  fu_output_t  pc, id, prd, rdval
fuoutput_o_valid  out  1  result valid
fuoutput_o_ready  in  1  writeback accepts result
squash_io  squash_if.slave  -  squash_io.valid flushes all in-flight ops
perf_issued_o  out  PERF_W  ops accepted (only with FU_MUL_PIPE_PERF_EN)
perf_stall_o  out  PERF_W  cycles with output valid and not ready (only with FU_MUL_PIPE_PERF_EN)

Behaviour:
- Reset: reset rstn, synchronous, active-low; clock clk. All stage valid bits cleared, so fuoutput_o_valid=0. fuinput_i_ready=0 while rstn=0. Payload registers are not reset.
- Stages: optional input stage S_in (REG_IN=1), multiplier (combinational), then PIPE_OUT stages S[PIPE_OUT-1]..S[0]. S[0] drives the outputs.
- Operand prep: MULW sign-extends rs1[31:0] and rs2[31:0] to 64 bits. Sign extension bit sa = a[63] for MULH/MULHSU; sb = b[63] for MULH only. Product = signed({sa,a}) * signed({sb,b}), truncated to 128 bits.
- Result select at S[0]:
  - MUL: val[63:0]
  - MULH/MULHU/MULHSU: val[127:64]
  - MULW: sext(val[31:0])
- Flow: a stage advances when it is empty or its downstream advances; S[0] advances when fuoutput_o_valid && fuoutput_o_ready. Bubbles collapse.
- fuinput_i_ready = !squash_io.valid && (first stage empty || first stage advancing). Transfer occurs iff valid && ready.
- Latency: REG_IN+PIPE_OUT cycles from accept to fuoutput_o_valid with no stall. Throughput is 1/cycle when fuoutput_o_ready=1.
- Capacity: REG_IN+PIPE_OUT ops in flight. When full and stalled, ready drops in the same cycle.
- Output stability: while fuoutput_o_valid=1 and fuoutput_o_ready=0, fuoutput_o is held unchanged.
- Squash: on any cycle with squash_io.valid=1:
  - all valid bits clear at the next edge;
  - no input is accepted;
  - a result presented in that cycle is not considered transferred.
  - Squash has priority over stall and advance.
- Order: results leave in acceptance order. No reordering.
- Reset mid-operation: all in-flight ops are discarded and never emerge.

Optional Feature:
FU_MUL_PIPE_PERF_EN
- Defined: perf_issued_o and perf_stall_o ports exist. Both counters are reset to 0, increment by 1 per qualifying cycle, and wrap modulo 2^PERF_W. Squash does not clear them.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package C gains:
  - mul_pipe_entry_t (pc, id, op, prd, val[2*XLEN], valid);
  - sext32to64 (already present).
- mul_set_t is reused unchanged.
- One sub-module, fu_mul_pipe_stage: a single valid/ready register slice with flush input, instantiated PIPE_OUT (+REG_IN) times via generate.

Test Plan:
- MUL rs1=3, rs2=5, ready=1 -> rdval=15 exactly REG_IN+PIPE_OUT cycles later, with id/prd/pc echoed.
- Signedness sweep:
  - MULH rs1=rs2=0xFFFFFFFFFFFFFFFF -> 0.
  - MULHU same operands -> 0xFFFFFFFFFFFFFFFE.
  - MULHSU rs1=-1, rs2=2 -> 0xFFFFFFFFFFFFFFFF.
  - MULW rs1=0x7FFFFFFF, rs2=2 -> 0xFFFFFFFFFFFFFFFE.
- Backpressure (REG_IN=1, PIPE_OUT=2): fuoutput_o_ready=0 with back-to-back valid inputs.
  - Expect exactly 3 accepts, then fuinput_i_ready=0 and fuoutput_o stable.
  - Release ready: 3 results emerge in order on consecutive cycles, and ready reasserts the same cycle the first one drains.
- Squash with 3 ops in flight and valid input asserted -> input not accepted, no result emerges afterwards, and the next op issued returns correctly at nominal latency.
- Reset asserted mid-stream for 1 cycle -> fuoutput_o_valid=0 next cycle, fuinput_i_ready=0 during reset, and no stale result ever emerges.
- With FU_MUL_PIPE_PERF_EN: 10 accepts and 4 stalled cycles -> perf_issued_o=10, perf_stall_o=4. Preload near 2^PERF_W-1 with PERF_W=4 and confirm the counters wrap to 0.

Source files
------------

// File: rtl/fu_mul_pipe_pkg.sv
// Shared types for the pipelined RV64 M-extension multiply unit.
// The operation set, the issue/writeback payloads and the per-stage pipeline entry
// are defined here, along with the 32->64 sign-extension helper.
package fu_mul_pipe_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned PROD_W = 2 * XLEN;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned PRD_W  = 6;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        MULW   = 3'd4
    } mul_set_t;

    typedef struct packed {
        mul_set_t mul;
    } fu_op_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [ID_W-1:0]  id;
        fu_op_t           op;
        logic [PRD_W-1:0] prd;
        logic [XLEN-1:0]  rs1val;
        logic [XLEN-1:0]  rs2val;
    } fu_input_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [ID_W-1:0]  id;
        logic [PRD_W-1:0] prd;
        logic [XLEN-1:0]  rdval;
    } fu_output_t;

    // One pipeline slot. Before the multiplier val carries {rs1, rs2};
    // after it, val carries the full 128-bit product.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [ID_W-1:0]   id;
        mul_set_t          op;
        logic [PRD_W-1:0]  prd;
        logic [PROD_W-1:0] val;
        logic              valid;
    } mul_pipe_entry_t;

    function automatic logic [63:0] sext32to64(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/squash_if.sv
// Pipeline flush request from the core: valid=1 kills every in-flight op.
interface squash_if;
    logic valid;
    modport master (output valid);
    modport slave  (input  valid);
endinterface

// File: rtl/fu_mul_pipe_stage.sv
// Single valid/ready register slice for the multiply pipeline.
// Loads when empty or when its content is being taken downstream, so bubbles
// collapse. Flush and reset clear only the valid bit; the payload is left as is.
module fu_mul_pipe_stage
    import fu_mul_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  mul_pipe_entry_t in_entry,
    output logic            in_ready,
    output mul_pipe_entry_t out_entry,
    input  logic            out_ready
);

    mul_pipe_entry_t entry_q;
    mul_pipe_entry_t entry_d;

    // Next slot content: clear on reset/flush, otherwise load whenever a slot frees up
    always_comb begin
        in_ready = !entry_q.valid || out_ready;
        entry_d  = entry_q;
        if (!rstn || flush) begin
            entry_d.valid = 1'b0;
        end else if (in_ready) begin
            entry_d = in_entry;
        end else begin
            entry_d = entry_q;
        end
    end

    // Slot register
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign out_entry = entry_q;

endmodule

// File: rtl/fu_mul_pipe.sv
// Backpressure-aware RV64 multiply functional unit (MUL/MULH/MULHSU/MULHU/MULW).
// Optional input slice (REG_IN), combinational 65x65 multiplier, then PIPE_OUT
// output slices; stage 0 drives the writeback interface and holds while stalled.
// Optional feature macro: FU_MUL_PIPE_PERF_EN adds issued/stall performance counters.
module fu_mul_pipe
    import fu_mul_pipe_pkg::*;
#(
    parameter int unsigned PIPE_OUT = 2,
    parameter int unsigned REG_IN   = 1,
    parameter int unsigned PERF_W   = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  fu_input_t  fuinput_i,
    input  logic       fuinput_i_valid,
    output logic       fuinput_i_ready,
    output fu_output_t fuoutput_o,
    output logic       fuoutput_o_valid,
    input  logic       fuoutput_o_ready,
    squash_if.slave    squash_io
`ifdef FU_MUL_PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_issued_o,
    output logic [PERF_W-1:0] perf_stall_o
`endif
);

    logic              squash_s;
    logic              front_ready_s;
    logic              accept_s;
    mul_pipe_entry_t   in_entry_s;
    mul_pipe_entry_t   mul_src_s;
    mul_pipe_entry_t   mul_res_s;
    mul_pipe_entry_t   stage_out_s [PIPE_OUT];
    logic              stage_rdy_s [PIPE_OUT];
    logic [XLEN-1:0]   op_a_s;
    logic [XLEN-1:0]   op_b_s;
    logic              sa_s;
    logic              sb_s;
    logic [PROD_W-1:0] prod_s;

    assign squash_s        = squash_io.valid;
    assign fuinput_i_ready = rstn && !squash_s && front_ready_s;
    assign accept_s        = fuinput_i_valid && fuinput_i_ready;

    // Pack the issued op; the operands ride in val until the multiplier replaces them
    always_comb begin
        in_entry_s.pc    = fuinput_i.pc;
        in_entry_s.id    = fuinput_i.id;
        in_entry_s.op    = fuinput_i.op.mul;
        in_entry_s.prd   = fuinput_i.prd;
        in_entry_s.val   = {fuinput_i.rs1val, fuinput_i.rs2val};
        in_entry_s.valid = accept_s;
    end

    generate
        if (REG_IN != 0) begin : g_reg_in
            fu_mul_pipe_stage u_in_stage (
                .clk       (clk),
                .rstn      (rstn),
                .flush     (squash_s),
                .in_entry  (in_entry_s),
                .in_ready  (front_ready_s),
                .out_entry (mul_src_s),
                .out_ready (stage_rdy_s[PIPE_OUT-1])
            );
        end else begin : g_comb_in
            assign mul_src_s     = in_entry_s;
            assign front_ready_s = stage_rdy_s[PIPE_OUT-1];
        end
    endgenerate

    // Operand prep and 65x65 signed multiply; the extra top bit selects signed/unsigned per op
    always_comb begin
        op_a_s = mul_src_s.val[PROD_W-1:XLEN];
        op_b_s = mul_src_s.val[XLEN-1:0];
        sa_s   = 1'b0;
        sb_s   = 1'b0;
        case (mul_src_s.op)
            MULH: begin
                sa_s = op_a_s[XLEN-1];
                sb_s = op_b_s[XLEN-1];
            end
            MULHSU: begin
                sa_s = op_a_s[XLEN-1];
            end
            MULW: begin
                op_a_s = sext32to64(mul_src_s.val[XLEN+31:XLEN]);
                op_b_s = sext32to64(mul_src_s.val[31:0]);
            end
            default: begin
                sa_s = 1'b0;
                sb_s = 1'b0;
            end
        endcase
        prod_s        = PROD_W'($signed({sa_s, op_a_s}) * $signed({sb_s, op_b_s}));
        mul_res_s     = mul_src_s;
        mul_res_s.val = prod_s;
    end

    generate
        for (genvar k = 0; k < PIPE_OUT; k++) begin : g_out
            mul_pipe_entry_t stg_in_s;
            logic            down_rdy_s;

            if (k == PIPE_OUT - 1) begin : g_from_mul
                assign stg_in_s = mul_res_s;
            end else begin : g_from_prev
                assign stg_in_s = stage_out_s[k+1];
            end

            if (k == 0) begin : g_to_wb
                assign down_rdy_s = fuoutput_o_ready;
            end else begin : g_to_next
                assign down_rdy_s = stage_rdy_s[k-1];
            end

            fu_mul_pipe_stage u_stage (
                .clk       (clk),
                .rstn      (rstn),
                .flush     (squash_s),
                .in_entry  (stg_in_s),
                .in_ready  (stage_rdy_s[k]),
                .out_entry (stage_out_s[k]),
                .out_ready (down_rdy_s)
            );
        end
    endgenerate

    // Pick the architectural result out of the full product held in the last slice
    always_comb begin
        fuoutput_o.pc  = stage_out_s[0].pc;
        fuoutput_o.id  = stage_out_s[0].id;
        fuoutput_o.prd = stage_out_s[0].prd;
        case (stage_out_s[0].op)
            MUL:                 fuoutput_o.rdval = stage_out_s[0].val[XLEN-1:0];
            MULH, MULHSU, MULHU: fuoutput_o.rdval = stage_out_s[0].val[PROD_W-1:XLEN];
            MULW:                fuoutput_o.rdval = sext32to64(stage_out_s[0].val[31:0]);
            default:             fuoutput_o.rdval = stage_out_s[0].val[XLEN-1:0];
        endcase
    end

    assign fuoutput_o_valid = stage_out_s[0].valid;

`ifdef FU_MUL_PIPE_PERF_EN
    logic [PERF_W-1:0] perf_issued_q;
    logic [PERF_W-1:0] perf_issued_d;
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_stall_d;

    // Count accepted ops and stalled result cycles; wrap freely, squash leaves them alone
    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_stall_d  = perf_stall_q;
        if (!rstn) begin
            perf_issued_d = {PERF_W{1'b0}};
            perf_stall_d  = {PERF_W{1'b0}};
        end else begin
            if (accept_s) begin
                perf_issued_d = perf_issued_q + PERF_W'(1);
            end else begin
                perf_issued_d = perf_issued_q;
            end
            if (fuoutput_o_valid && !fuoutput_o_ready) begin
                perf_stall_d = perf_stall_q + PERF_W'(1);
            end else begin
                perf_stall_d = perf_stall_q;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        perf_issued_q <= perf_issued_d;
        perf_stall_q  <= perf_stall_d;
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`else
    localparam int unsigned unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Self-checking bench for fu_mul_pipe (REG_IN=1, PIPE_OUT=2).
// Expected results are pushed to a scoreboard queue when an op is accepted and
// compared when the unit hands a result to writeback.
module tb_fu_mul_pipe;
    import fu_mul_pipe_pkg::*;

    localparam int LAT = 3;

    typedef struct packed {
        logic [63:0] pc;
        logic [7:0]  id;
        logic [5:0]  prd;
        logic [63:0] rdval;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    fu_input_t  fin;
    logic       fin_valid;
    logic       fin_ready;
    fu_output_t fout;
    logic       fout_valid;
    logic       fout_ready;
    squash_if   sq_if ();
`ifdef FU_MUL_PIPE_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          tag   = 0;
    logic [63:0] drv_exp;
    exp_t        sb[$];
    logic        prev_hold = 1'b0;
    exp_t        prev_out;

    always #5 clk = ~clk;

    fu_mul_pipe #(.PIPE_OUT(2), .REG_IN(1), .PERF_W(32)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .fuinput_i        (fin),
        .fuinput_i_valid  (fin_valid),
        .fuinput_i_ready  (fin_ready),
        .fuoutput_o       (fout),
        .fuoutput_o_valid (fout_valid),
        .fuoutput_o_ready (fout_ready),
        .squash_io        (sq_if)
`ifdef FU_MUL_PIPE_PERF_EN
        ,
        .perf_issued_o    (perf_issued),
        .perf_stall_o     (perf_stall)
`endif
    );

    function automatic logic [63:0] ref_mul(input mul_set_t op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        logic [31:0]  w;
        ea = {64'd0, a};
        eb = {64'd0, b};
        if (op == MULH || op == MULHSU) ea = {{64{a[63]}}, a};
        if (op == MULH) eb = {{64{b[63]}}, b};
        p = ea * eb;
        w = a[31:0] * b[31:0];
        case (op)
            MUL:     return a * b;
            MULW:    return {{32{w[31]}}, w};
            default: return p[127:64];
        endcase
    endfunction

    // Scoreboard monitor: handshakes seen here complete at the following rising edge
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        got = {fout.pc, fout.id, fout.prd, fout.rdval};
        if (!rstn || sq_if.valid) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                n_vec++;
                if (!fout_valid || got !== prev_out) begin
                    n_err++;
                    $display("FAIL hold_stable got %h v=%b required %h v=1", got, fout_valid, prev_out);
                end
            end
            if (fout_valid && fout_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result got %h required none", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL result got %h required %h", got, e);
                    end
                end
            end
            if (fin_valid && fin_ready) begin
                sb.push_back({fin.pc, fin.id, fin.prd, drv_exp});
            end
            prev_hold = fout_valid && !fout_ready;
            prev_out  = got;
        end
    end

    task automatic drive_op(input mul_set_t op, input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
        tag++;
        fin.pc     = 64'h8000_0000 + 64'(tag * 4);
        fin.id     = 8'(tag);
        fin.prd    = 6'(tag * 7);
        fin.op.mul = op;
        fin.rs1val = a;
        fin.rs2val = b;
        drv_exp    = e;
        fin_valid  = 1'b1;
    endtask

    task automatic drive_rand();
        mul_set_t    op;
        logic [63:0] a;
        logic [63:0] b;
        op = mul_set_t'($urandom_range(0, 4));
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        drive_op(op, a, b, ref_mul(op, a, b));
    endtask

    // Ends just after the accepting rising edge with fin_valid still high
    task automatic wait_accept();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = fin_ready;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout got ready=0 required ready=1");
        end
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !fout_valid;
        end
        @(posedge clk);
        #1;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout got pending=%0d required 0", sb.size());
        end
    endtask

    task automatic check_latency(input mul_set_t op, input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
        int lat;
        drive_op(op, a, b, e);
        wait_accept();
        fin_valid = 1'b0;
        lat = 0;
        while (!fout_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != LAT) begin
            n_err++;
            $display("FAIL latency got %0d required %0d", lat, LAT);
        end
        wait_drain();
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        fin_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (fout_valid !== 1'b0 || fin_ready !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state got v=%b r=%b required v=0 r=0", fout_valid, fin_ready);
            end
        end
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        fin_valid = 1'b0;
    endtask

    task automatic test_basic();
        check_latency(MUL, 64'd3, 64'd5, 64'd15);
    endtask

    task automatic test_signedness();
        drive_op(MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        wait_accept();
        drive_op(MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_accept();
        drive_op(MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_accept();
        drive_op(MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_accept();
        drive_op(MULHSU, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        wait_accept();
        drive_op(MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9);
        wait_accept();
        fin_valid = 1'b0;
        wait_drain();
    endtask

    // Stall the writeback, keep issuing, return with the unit full and fin_valid high
    task automatic fill_stalled(output int acc, output logic last_rdy);
        fout_ready = 1'b0;
        acc = 0;
        last_rdy = 1'b1;
        drive_rand();
        repeat (6) begin
            logic took;
            @(negedge clk);
            took = fin_valid && fin_ready;
            last_rdy = fin_ready;
            @(posedge clk);
            #1;
            if (took) begin
                acc++;
                drive_rand();
            end
        end
    endtask

    task automatic test_backpressure();
        int   acc;
        logic last_rdy;
        fill_stalled(acc, last_rdy);
        n_vec++;
        if (acc != 3 || last_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_capacity got acc=%0d ready=%b required acc=3 ready=0", acc, last_rdy);
        end
        fin_valid  = 1'b0;
        fout_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (fin_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready_reassert got %b required 1", fin_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++;
            if (fout_valid !== (i < 3)) begin
                n_err++;
                $display("FAIL bp_drain_slot%0d got v=%b required %b", i, fout_valid, (i < 3));
            end
        end
        wait_drain();
    endtask

    task automatic test_squash();
        int   acc;
        logic last_rdy;
        logic seen;
        fill_stalled(acc, last_rdy);
        sq_if.valid = 1'b1;
        @(negedge clk);
        n_vec++;
        if (fin_ready !== 1'b0) begin
            n_err++;
            $display("FAIL squash_ready got %b required 0", fin_ready);
        end
        @(posedge clk);
        #1;
        sq_if.valid = 1'b0;
        fin_valid   = 1'b0;
        fout_ready  = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | fout_valid;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL squash_leak got valid=1 required 0");
        end
        @(posedge clk);
        #1;
        check_latency(MULHU, 64'h0000_0001_0000_0000, 64'h0000_0003_0000_0000, 64'd3);
    endtask

    task automatic test_reset_mid();
        logic seen;
        fout_ready = 1'b1;
        repeat (3) begin
            drive_rand();
            wait_accept();
        end
        rstn = 1'b0;
        @(negedge clk);
        n_vec++;
        if (fin_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_ready got %b required 0", fin_ready);
        end
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        fin_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (fout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_valid got %b required 0", fout_valid);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | fout_valid;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_stale got valid=1 required 0");
        end
        @(posedge clk);
        #1;
        check_latency(MULW, 64'hDEAD_BEEF_0000_0010, 64'h1234_5678_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFD0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic got;
            drive_rand();
            got = 1'b0;
            for (int j = 0; j < 50 && !got; j++) begin
                @(negedge clk);
                got = fin_ready;
                @(posedge clk);
                #1;
                fout_ready = ($urandom_range(0, 3) != 0);
            end
            if (!got) begin
                n_vec++;
                n_err++;
                $display("FAIL rand_accept_timeout got ready=0 required ready=1");
            end
        end
        fin_valid  = 1'b0;
        fout_ready = 1'b1;
        wait_drain();
    endtask

`ifdef FU_MUL_PIPE_PERF_EN
    task automatic test_perf();
        logic found;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        n_vec++;
        if (perf_issued !== 32'd0 || perf_stall !== 32'd0) begin
            n_err++;
            $display("FAIL perf_reset got %0d/%0d required 0/0", perf_issued, perf_stall);
        end
        fout_ready = 1'b1;
        repeat (9) begin
            drive_rand();
            wait_accept();
        end
        fin_valid = 1'b0;
        wait_drain();
        fout_ready = 1'b0;
        drive_rand();
        wait_accept();
        fin_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = fout_valid;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        fout_ready = 1'b1;
        wait_drain();
        n_vec++;
        if (perf_issued !== 32'd10 || perf_stall !== 32'd4) begin
            n_err++;
            $display("FAIL perf_counts got %0d/%0d required 10/4", perf_issued, perf_stall);
        end
    endtask
`endif

    initial begin
        fin         = '0;
        fin_valid   = 1'b0;
        fout_ready  = 1'b1;
        sq_if.valid = 1'b0;
        drv_exp     = 64'd0;
        test_reset();
        test_basic();
        test_signedness();
        test_backpressure();
        test_squash();
        test_reset_mid();
        test_random();
`ifdef FU_MUL_PIPE_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
